// File: rtl/alu_req_arbiter.sv
// Two-port round-robin front end for a single shared ALU.
// One operation in flight: accept, wait ALU_LAT edges, hold the result until consumed.
module alu_req_arbiter #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned OPW     = 6,
   parameter int unsigned ALU_LAT = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req0_valid_i,
   output logic            req0_ready_o,
   input  logic [OPW-1:0]  req0_op_i,
   input  logic [XLEN-1:0] req0_a_i,
   input  logic [XLEN-1:0] req0_b_i,
   input  logic [4:0]      req0_shamt_i,
   output logic            rsp0_valid_o,
   input  logic            rsp0_ready_i,
   output logic [XLEN-1:0] rsp0_result_o,
   input  logic            req1_valid_i,
   output logic            req1_ready_o,
   input  logic [OPW-1:0]  req1_op_i,
   input  logic [XLEN-1:0] req1_a_i,
   input  logic [XLEN-1:0] req1_b_i,
   input  logic [4:0]      req1_shamt_i,
   output logic            rsp1_valid_o,
   input  logic            rsp1_ready_i,
   output logic [XLEN-1:0] rsp1_result_o,
   output logic [OPW-1:0]  alu_op_o,
   output logic [XLEN-1:0] alu_a_o,
   output logic [XLEN-1:0] alu_b_o,
   output logic [4:0]      alu_shamt_o,
   input  logic [XLEN-1:0] alu_result_i
);

   localparam int unsigned CW       = 3;
   localparam logic [CW-1:0] LAT_LAST = CW'(ALU_LAT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              owner_q;
   logic              rr_q;
   logic [CW-1:0]     lat_cnt_q;
   logic [XLEN-1:0]   result_q;
   logic              grant0, grant1;
   logic              accept;
   logic              rsp_hs;
   logic              lat_done;

   // Round-robin pointer only breaks ties; a lone requester always wins.
   assign grant0 = req0_valid_i && (!req1_valid_i || !rr_q);
   assign grant1 = req1_valid_i && (!req0_valid_i || rr_q);

   assign req0_ready_o = !rst_i && (state_q == IDLE) && grant0;
   assign req1_ready_o = !rst_i && (state_q == IDLE) && grant1;
   assign accept       = req0_ready_o || req1_ready_o;

   assign rsp0_valid_o  = (state_q == RESP) && !owner_q;
   assign rsp1_valid_o  = (state_q == RESP) && owner_q;
   assign rsp0_result_o = result_q;
   assign rsp1_result_o = result_q;
   assign rsp_hs        = (rsp0_valid_o && rsp0_ready_i) || (rsp1_valid_o && rsp1_ready_i);
   assign lat_done      = (state_q == BUSY) && (lat_cnt_q == LAT_LAST);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept)   state_d = BUSY;
         BUSY:    if (lat_done) state_d = RESP;
         RESP:    if (rsp_hs)   state_d = IDLE;
         default:               state_d = IDLE;
      endcase
   end

   // Operand launch, latency count and result capture.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         owner_q     <= 1'b0;
         rr_q        <= 1'b0;
         lat_cnt_q   <= '0;
         result_q    <= '0;
         alu_op_o    <= '0;
         alu_a_o     <= '0;
         alu_b_o     <= '0;
         alu_shamt_o <= '0;
      end else begin
         if (accept) begin
            alu_op_o    <= grant1 ? req1_op_i    : req0_op_i;
            alu_a_o     <= grant1 ? req1_a_i     : req0_a_i;
            alu_b_o     <= grant1 ? req1_b_i     : req0_b_i;
            alu_shamt_o <= grant1 ? req1_shamt_i : req0_shamt_i;
            owner_q     <= grant1;
            rr_q        <= !grant1;
            lat_cnt_q   <= '0;
         end else if (state_q == BUSY) begin
            lat_cnt_q   <= lat_cnt_q + CW'(1);
         end
         if (lat_done) begin
            result_q    <= alu_result_i;
         end
      end
   end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter: one instance with ALU_LAT=1, one with ALU_LAT=3,
// both fed by an A+B ALU model; expectations are queued on accept and popped on response.
module tb_alu_req_arbiter;

   typedef struct packed {
      logic        port;
      logic [31:0] res;
      logic [31:0] cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
   logic [5:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [4:0]  req0_shamt, req1_shamt;

   logic        l1_req0_ready, l1_req1_ready, l1_rsp0_valid, l1_rsp1_valid;
   logic [31:0] l1_rsp0_result, l1_rsp1_result, l1_alu_a, l1_alu_b, l1_alu_res;
   logic [5:0]  l1_alu_op;
   logic [4:0]  l1_alu_shamt;

   logic        l3_req0_ready, l3_req1_ready, l3_rsp0_valid, l3_rsp1_valid;
   logic [31:0] l3_rsp0_result, l3_rsp1_result, l3_alu_a, l3_alu_b, l3_alu_res;
   logic [5:0]  l3_alu_op;
   logic [4:0]  l3_alu_shamt;
   logic [3:0]  l3_cnt;

   logic [31:0] cyc = '0;
   exp_t        q1[$];
   exp_t        q3[$];
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   alu_req_arbiter #(.XLEN(32), .OPW(6), .ALU_LAT(1)) u_l1 (
      .clk_i(clk), .rst_i(rst),
      .req0_valid_i(req0_valid), .req0_ready_o(l1_req0_ready), .req0_op_i(req0_op),
      .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_shamt_i(req0_shamt),
      .rsp0_valid_o(l1_rsp0_valid), .rsp0_ready_i(rsp0_ready), .rsp0_result_o(l1_rsp0_result),
      .req1_valid_i(req1_valid), .req1_ready_o(l1_req1_ready), .req1_op_i(req1_op),
      .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_shamt_i(req1_shamt),
      .rsp1_valid_o(l1_rsp1_valid), .rsp1_ready_i(rsp1_ready), .rsp1_result_o(l1_rsp1_result),
      .alu_op_o(l1_alu_op), .alu_a_o(l1_alu_a), .alu_b_o(l1_alu_b),
      .alu_shamt_o(l1_alu_shamt), .alu_result_i(l1_alu_res)
   );

   alu_req_arbiter #(.XLEN(32), .OPW(6), .ALU_LAT(3)) u_l3 (
      .clk_i(clk), .rst_i(rst),
      .req0_valid_i(req0_valid), .req0_ready_o(l3_req0_ready), .req0_op_i(req0_op),
      .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_shamt_i(req0_shamt),
      .rsp0_valid_o(l3_rsp0_valid), .rsp0_ready_i(rsp0_ready), .rsp0_result_o(l3_rsp0_result),
      .req1_valid_i(req1_valid), .req1_ready_o(l3_req1_ready), .req1_op_i(req1_op),
      .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_shamt_i(req1_shamt),
      .rsp1_valid_o(l3_rsp1_valid), .rsp1_ready_i(rsp1_ready), .rsp1_result_o(l3_rsp1_result),
      .alu_op_o(l3_alu_op), .alu_a_o(l3_alu_a), .alu_b_o(l3_alu_b),
      .alu_shamt_o(l3_alu_shamt), .alu_result_i(l3_alu_res)
   );

   // ALU models: latency 1 is a plain adder; latency 3 returns garbage until 3 edges after launch.
   assign l1_alu_res = l1_alu_a + l1_alu_b;
   assign l3_alu_res = (l3_cnt >= 4'd2) ? (l3_alu_a + l3_alu_b) : 32'hDEAD_BEEF;

   always @(posedge clk or posedge rst) begin
      if (rst) l3_cnt <= '0;
      else if ((req0_valid && l3_req0_ready) || (req1_valid && l3_req1_ready)) l3_cnt <= '0;
      else if (l3_cnt != 4'hF) l3_cnt <= l3_cnt + 4'd1;
   end

   // Scoreboard producer: expected result computed from the accepted payload.
   always @(posedge clk) begin
      if (!rst) begin
         if (req0_valid && l1_req0_ready) q1.push_back('{1'b0, 32'(req0_a + req0_b), cyc});
         if (req1_valid && l1_req1_ready) q1.push_back('{1'b1, 32'(req1_a + req1_b), cyc});
         if (req0_valid && l3_req0_ready) q3.push_back('{1'b0, 32'(req0_a + req0_b), cyc});
         if (req1_valid && l3_req1_ready) q3.push_back('{1'b1, 32'(req1_a + req1_b), cyc});
      end
      cyc <= cyc + 32'd1;
   end

   task automatic set_idle();
      req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      req0_op = '0; req1_op = '0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      req0_shamt = '0; req1_shamt = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      set_idle();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      q1.delete();
      q3.delete();
   endtask

   task automatic wait_rsp(input bit use3, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (use3 ? (l3_rsp0_valid || l3_rsp1_valid) : (l1_rsp0_valid || l1_rsp1_valid)) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic pop_exp(input bit use3, output exp_t e, output bit ok);
      ok = 1'b0;
      e  = '0;
      if (use3 && q3.size() != 0) begin e = q3.pop_front(); ok = 1'b1; end
      if (!use3 && q1.size() != 0) begin e = q1.pop_front(); ok = 1'b1; end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_idle();
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk); #1;
      n_cmp++; if (l1_req0_ready !== 1'b0 || l1_req1_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b%b want 00", l1_req0_ready, l1_req1_ready); end
      n_cmp++; if (l1_rsp0_valid !== 1'b0 || l1_rsp1_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b%b want 00", l1_rsp0_valid, l1_rsp1_valid); end
      n_cmp++; if (l1_alu_a !== 32'd0 || l1_alu_b !== 32'd0 || l1_alu_op !== 6'd0 || l1_alu_shamt !== 5'd0) begin n_err++; $display("FAIL reset_alu: got a=%h b=%h op=%h sh=%h want 0", l1_alu_a, l1_alu_b, l1_alu_op, l1_alu_shamt); end
      n_cmp++; if (l1_rsp0_result !== 32'd0 || l1_rsp1_result !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h %h want 0", l1_rsp0_result, l1_rsp1_result); end
      n_cmp++; if (l3_req0_ready !== 1'b0 || l3_alu_op !== 6'd0) begin n_err++; $display("FAIL reset_l3: got rdy=%b op=%h want 0", l3_req0_ready, l3_alu_op); end
      rst = 1'b0;
      #1;
      n_cmp++; if (l1_req0_ready !== 1'b1 || l1_req1_ready !== 1'b0) begin n_err++; $display("FAIL reset_prio: got %b%b want 10", l1_req0_ready, l1_req1_ready); end
   endtask

   task automatic test_single();
      exp_t e; bit ok;
      do_reset();
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 6'h2A; req0_shamt = 5'd9;
      #1;
      n_cmp++; if (l1_req0_ready !== 1'b1 || l1_req1_ready !== 1'b0) begin n_err++; $display("FAIL single_grant: got %b%b want 10", l1_req0_ready, l1_req1_ready); end
      @(negedge clk); req0_valid = 1'b0; #1;
      n_cmp++; if (l1_req0_ready !== 1'b0) begin n_err++; $display("FAIL single_ready_busy: got %b want 0", l1_req0_ready); end
      n_cmp++; if (l1_alu_a !== 32'd5 || l1_alu_b !== 32'd7 || l1_alu_op !== 6'h2A || l1_alu_shamt !== 5'd9) begin n_err++; $display("FAIL single_launch: got a=%h b=%h op=%h sh=%h want 5 7 2a 9", l1_alu_a, l1_alu_b, l1_alu_op, l1_alu_shamt); end
      n_cmp++; if (l1_rsp0_valid !== 1'b0) begin n_err++; $display("FAIL single_early_rsp: got %b want 0", l1_rsp0_valid); end
      @(negedge clk); #1;
      n_cmp++; if (l1_rsp0_valid !== 1'b1 || l1_rsp1_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp_valid: got %b%b want 10", l1_rsp0_valid, l1_rsp1_valid); end
      pop_exp(1'b0, e, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL single_sb: got empty queue want 1 entry"); end
      n_cmp++; if (l1_rsp0_result !== e.res || e.res !== 32'd12) begin n_err++; $display("FAIL single_result: got %0d want 12", l1_rsp0_result); end
      @(negedge clk); #1;
      n_cmp++; if (l1_rsp0_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp_drop: got %b want 0", l1_rsp0_valid); end
   endtask

   task automatic test_alternate();
      exp_t e; bit ok, seen, rport;
      logic [31:0] rres, prev;
      prev = '0;
      do_reset();
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1;
      req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2;
      for (int k = 0; k < 4; k++) begin
         wait_rsp(1'b0, seen);
         n_cmp++; if (!seen) begin n_err++; $display("FAIL alt_timeout: k=%0d no response within 20 cycles", k); end
         rport = l1_rsp1_valid;
         rres  = rport ? l1_rsp1_result : l1_rsp0_result;
         n_cmp++; if ((l1_rsp0_valid && l1_rsp1_valid) !== 1'b0) begin n_err++; $display("FAIL alt_both_valid: k=%0d got 1 want 0", k); end
         pop_exp(1'b0, e, ok);
         n_cmp++; if (!ok || e.port !== k[0]) begin n_err++; $display("FAIL alt_grant_order: k=%0d got port %b want %b", k, e.port, k[0]); end
         n_cmp++; if (rport !== e.port || rres !== e.res) begin n_err++; $display("FAIL alt_result: k=%0d got port %b res %0d want port %b res %0d", k, rport, rres, e.port, e.res); end
         if (k > 0) begin
            n_cmp++; if (e.cyc - prev !== 32'd3) begin n_err++; $display("FAIL alt_spacing: k=%0d got %0d cycles want 3", k, e.cyc - prev); end
         end
         prev = e.cyc;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      exp_t e; bit ok, seen;
      do_reset();
      @(negedge clk);
      rsp0_ready = 1'b0; req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20;
      #1;
      n_cmp++; if (l1_req0_ready !== 1'b1) begin n_err++; $display("FAIL bp_grant0: got %b want 1", l1_req0_ready); end
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4;
      wait_rsp(1'b0, seen);
      n_cmp++; if (!seen) begin n_err++; $display("FAIL bp_timeout: no response within 20 cycles"); end
      pop_exp(1'b0, e, ok);
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (l1_rsp0_valid !== 1'b1 || l1_rsp0_result !== e.res || e.res !== 32'd30) begin n_err++; $display("FAIL bp_hold: i=%0d got v=%b res=%0d want v=1 res=30", i, l1_rsp0_valid, l1_rsp0_result); end
         n_cmp++; if (l1_req1_ready !== 1'b0) begin n_err++; $display("FAIL bp_no_grant1: i=%0d got %b want 0", i, l1_req1_ready); end
         @(negedge clk); #1;
      end
      rsp0_ready = 1'b1;
      #1;
      n_cmp++; if (l1_req1_ready !== 1'b0) begin n_err++; $display("FAIL bp_grant_early: got %b want 0", l1_req1_ready); end
      @(negedge clk); #1;
      n_cmp++; if (l1_req1_ready !== 1'b1 || l1_rsp0_valid !== 1'b0) begin n_err++; $display("FAIL bp_grant1_after: got rdy=%b v0=%b want 1 0", l1_req1_ready, l1_rsp0_valid); end
      @(negedge clk); req1_valid = 1'b0;
      wait_rsp(1'b0, seen);
      pop_exp(1'b0, e, ok);
      n_cmp++; if (!seen || !ok || l1_rsp1_valid !== 1'b1 || e.port !== 1'b1 || l1_rsp1_result !== e.res) begin n_err++; $display("FAIL bp_rsp1: got v=%b res=%0d want v=1 res=%0d", l1_rsp1_valid, l1_rsp1_result, e.res); end
   endtask

   task automatic test_lat3();
      exp_t e; bit ok;
      do_reset();
      @(negedge clk);
      req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_op = 6'h11; req1_shamt = 5'd31;
      #1;
      n_cmp++; if (l3_req1_ready !== 1'b1 || l3_req0_ready !== 1'b0) begin n_err++; $display("FAIL lat3_grant: got %b%b want 01", l3_req1_ready, l3_req0_ready); end
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (i == 1) req1_valid = 1'b0;
         #1;
         n_cmp++; if (l3_rsp1_valid !== (i == 4) || l3_rsp0_valid !== 1'b0) begin n_err++; $display("FAIL lat3_timing: edge %0d got v1=%b v0=%b want %b 0", i, l3_rsp1_valid, l3_rsp0_valid, (i == 4)); end
         n_cmp++; if (l3_alu_a !== 32'hFFFF_FFFF || l3_alu_b !== 32'd1 || l3_alu_op !== 6'h11 || l3_alu_shamt !== 5'd31) begin n_err++; $display("FAIL lat3_stable: edge %0d got a=%h b=%h op=%h sh=%h", i, l3_alu_a, l3_alu_b, l3_alu_op, l3_alu_shamt); end
      end
      pop_exp(1'b1, e, ok);
      n_cmp++; if (!ok || e.port !== 1'b1 || l3_rsp1_result !== e.res || e.res !== 32'd0) begin n_err++; $display("FAIL lat3_result: got %h want 00000000", l3_rsp1_result); end
      @(negedge clk); #1;
      n_cmp++; if (l3_rsp1_valid !== 1'b0 || l3_alu_a !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL lat3_after: got v=%b a=%h want 0 ffffffff", l3_rsp1_valid, l3_alu_a); end
   endtask

   task automatic test_reset_busy();
      exp_t e; bit ok, seen;
      do_reset();
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9;
      #1;
      n_cmp++; if (l3_req0_ready !== 1'b1) begin n_err++; $display("FAIL rb_grant0: got %b want 1", l3_req0_ready); end
      @(negedge clk); req0_valid = 1'b0; #1;
      n_cmp++; if (l3_alu_a !== 32'd9) begin n_err++; $display("FAIL rb_launch: got %0d want 9", l3_alu_a); end
      rst = 1'b1;
      #1;
      n_cmp++; if (l3_alu_a !== 32'd0 || l3_alu_b !== 32'd0 || l3_rsp0_valid !== 1'b0 || l3_rsp0_result !== 32'd0) begin n_err++; $display("FAIL rb_async: got a=%h b=%h v=%b res=%h want 0", l3_alu_a, l3_alu_b, l3_rsp0_valid, l3_rsp0_result); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      q1.delete(); q3.delete();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         n_cmp++; if ((l3_rsp0_valid || l3_rsp1_valid) !== 1'b0) begin n_err++; $display("FAIL rb_ghost_rsp: cycle %0d got 1 want 0", i); end
      end
      @(negedge clk);
      req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2;
      #1;
      n_cmp++; if (l3_req1_ready !== 1'b1) begin n_err++; $display("FAIL rb_grant1: got %b want 1", l3_req1_ready); end
      @(negedge clk); req1_valid = 1'b0;
      wait_rsp(1'b1, seen);
      pop_exp(1'b1, e, ok);
      n_cmp++; if (!seen || !ok || l3_rsp1_valid !== 1'b1 || e.port !== 1'b1 || l3_rsp1_result !== e.res) begin n_err++; $display("FAIL rb_rsp1: got v=%b res=%0d want v=1 res=3", l3_rsp1_valid, l3_rsp1_result); end
      req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd6;
      req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd8;
      @(negedge clk); #1;
      n_cmp++; if (l3_req0_ready !== 1'b1 || l3_req1_ready !== 1'b0) begin n_err++; $display("FAIL rb_rr_after: got %b%b want 10", l3_req0_ready, l3_req1_ready); end
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_drop_busy();
      exp_t e; bit ok, seen;
      do_reset();
      @(negedge clk);
      rsp1_ready = 1'b0; req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd4;
      #1;
      n_cmp++; if (l1_req1_ready !== 1'b1) begin n_err++; $display("FAIL drop_grant1: got %b want 1", l1_req1_ready); end
      @(negedge clk);
      req1_valid = 1'b0; req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd1;
      #1;
      n_cmp++; if (l1_req0_ready !== 1'b0) begin n_err++; $display("FAIL drop_busy_ready: got %b want 0", l1_req0_ready); end
      @(negedge clk); #1;
      n_cmp++; if (l1_rsp1_valid !== 1'b1 || l1_req0_ready !== 1'b0) begin n_err++; $display("FAIL drop_resp: got v1=%b rdy0=%b want 1 0", l1_rsp1_valid, l1_req0_ready); end
      req0_valid = 1'b0;
      repeat (2) @(negedge clk);
      rsp1_ready = 1'b1;
      pop_exp(1'b0, e, ok);
      n_cmp++; if (!ok || e.port !== 1'b1 || l1_rsp1_result !== e.res || e.res !== 32'd8) begin n_err++; $display("FAIL drop_result: got %0d want 8", l1_rsp1_result); end
      @(negedge clk); #1;
      req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd5;
      #1;
      n_cmp++; if (l1_req1_ready !== 1'b1 || l1_req0_ready !== 1'b0) begin n_err++; $display("FAIL drop_lone1: got %b%b want 01", l1_req1_ready, l1_req0_ready); end
      n_cmp++; if (q1.size() !== 0) begin n_err++; $display("FAIL drop_no_accept0: got %0d queued want 0", q1.size()); end
      @(negedge clk); req1_valid = 1'b0;
      wait_rsp(1'b0, seen);
      pop_exp(1'b0, e, ok);
      n_cmp++; if (!seen || !ok || e.port !== 1'b1 || l1_rsp1_result !== e.res || e.res !== 32'd10) begin n_err++; $display("FAIL drop_rsp2: got %0d want 10", l1_rsp1_result); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_alternate();
      test_backpressure();
      test_lat3();
      test_reset_busy();
      test_drop_busy();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
